// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Patterns are active-high, bit6=a .. bit0=g.
package seg7_pkg;

    typedef enum logic [1:0] {
        HEX,
        BLANK,
        ILLEGAL
    } seg_kind_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam int CNT_W = 8;

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational lookup from an active-high segment pattern
// to a hex nibble plus a hex/blank/illegal classification.
module seg7_to_nibble
    import seg7_pkg::*;
(
    input  logic [6:0] p,
    output logic [3:0] nibble,
    output seg_kind_e  kind
);

    always_comb begin
        nibble = 4'h0;
        kind   = (p == SEG_BLANK) ? BLANK : ILLEGAL;
        for (int i = 0; i < 16; i++) begin
            if (p == SEG_HEX[i]) begin
                nibble = 4'(i);
                kind   = HEX;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reads back a scanned active-low 7-seg bus: debounces each digit's
// pattern, decodes it and keeps per-digit value/valid/bad state.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     bad,
    output logic                  update,
    output logic [2:0]            upd_idx,
    output logic                  frame_done
);

    localparam logic [CNT_W-1:0] ST = CNT_W'(STABLE_CYCLES);

    logic [6:0]        seg_q;
    logic [DIGITS-1:0] dig_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              cap_q;
    logic              cap_nxt;
    logic [DIGITS-1:0] seen;
    logic [DIGITS-1:0] seen_nxt;
    logic [DIGITS-1:0] sel;
    logic [DIGITS-1:0] sel_q;
    logic              legal;
    logic              same;
    logic [3:0]        nibble;
    seg_kind_e         kind;

    assign sel   = ~dig_n;
    assign sel_q = ~dig_q;
    assign legal = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign same  = ({seg_n, dig_n} == {seg_q, dig_q});

    // Capture only on the transition into ST, so a held pair fires once.
    always_comb begin
        cnt_nxt = '0;
        cap_nxt = 1'b0;
        if (legal) begin
            if (!same)
                cnt_nxt = CNT_W'(1);
            else if (cnt >= ST)
                cnt_nxt = ST;
            else
                cnt_nxt = cnt + 1'b1;
            cap_nxt = (cnt_nxt == ST) && !(same && cnt == ST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '0;
            dig_q <= '0;
            cnt   <= '0;
            cap_q <= 1'b0;
        end else begin
            seg_q <= seg_n;
            dig_q <= dig_n;
            cnt   <= cnt_nxt;
            cap_q <= cap_nxt;
        end
    end

    seg7_to_nibble u_dec (
        .p      (~seg_q),
        .nibble (nibble),
        .kind   (kind)
    );

    assign seen_nxt = seen | sel_q;

    // The sample register still holds the captured pair one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value      <= '0;
            valid      <= '0;
            bad        <= '0;
            update     <= 1'b0;
            upd_idx    <= '0;
            frame_done <= 1'b0;
            seen       <= '0;
        end else begin
            update     <= cap_q;
            frame_done <= 1'b0;
            if (cap_q) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel_q[i]) begin
                        upd_idx <= 3'(i);
                        unique case (kind)
                            HEX: begin
                                value[4*i +: 4] <= nibble;
                                valid[i]        <= 1'b1;
                                bad[i]          <= 1'b0;
                            end
                            BLANK: begin
                                value[4*i +: 4] <= 4'h0;
                                valid[i]        <= 1'b0;
                                bad[i]          <= 1'b0;
                            end
                            default: begin
                                valid[i] <= 1'b0;
                                bad[i]   <= 1'b1;
                            end
                        endcase
                    end
                end
                if (&seen_nxt) begin
                    seen       <= '0;
                    frame_done <= 1'b1;
                end else begin
                    seen <= seen_nxt;
                end
            end
        end
    end

endmodule
